// File: rtl/fetch_if.sv
// Handshake/bus bundle between the fetch sequencer, instmem, hazard unit and IF/ID consumer.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault_clr;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_addr;

  modport master (
    output stall, redirect, redirect_pc, fault_clr, inst_in,
    input  inst_addr, if_inst, if_pc, if_pc4, if_valid, fault, fault_addr
  );

  modport slave (
    input  stall, redirect, redirect_pc, fault_clr, inst_in,
    output inst_addr, if_inst, if_pc, if_pc4, if_valid, fault, fault_addr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads instmem combinationally and fills the IF/ID latch.
// state | meaning
// RUN   | fetching; redirect > stall > bad_pc > sequential fetch
// FAULT | misaligned/out-of-range PC seen; waits for fault_clr
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NO_INST  = 1024,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  localparam logic [31:0] LP_NO_INST = 32'(NO_INST);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;
  logic [31:0] r_fault_addr;
  logic [31:0] w_pc4;
  logic        w_bad_pc;

  assign w_pc4    = r_pc + 32'd4;
  assign w_bad_pc = (r_pc[1:0] != 2'b00) | ({2'b00, r_pc[31:2]} >= LP_NO_INST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (!bus.redirect && !bus.stall && w_bad_pc) w_state_nxt = ST_FAULT;
      ST_FAULT: if (bus.fault_clr) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.inst_addr  = r_pc;
    bus.if_inst    = r_if_inst;
    bus.if_pc      = r_if_pc;
    bus.if_pc4     = r_if_pc4;
    bus.if_valid   = r_if_valid;
    bus.fault      = (r_state == ST_FAULT);
    bus.fault_addr = r_fault_addr;
  end

  // Redirect masks bad_pc: the flushed fetch is never consumed, so it cannot fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_if_inst    <= NOP_INST;
      r_if_pc      <= 32'd0;
      r_if_pc4     <= 32'd0;
      r_if_valid   <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (r_state == ST_RUN) begin
      if (bus.redirect) begin
        r_pc       <= bus.redirect_pc;
        r_if_inst  <= NOP_INST;
        r_if_valid <= 1'b0;
        r_if_pc    <= r_pc;
        r_if_pc4   <= w_pc4;
      end else if (!bus.stall) begin
        if (w_bad_pc) begin
          r_fault_addr <= r_pc;
          r_if_inst    <= NOP_INST;
          r_if_valid   <= 1'b0;
        end else begin
          r_pc       <= w_pc4;
          r_if_inst  <= bus.inst_in;
          r_if_pc    <= r_pc;
          r_if_pc4   <= w_pc4;
          r_if_valid <= 1'b1;
        end
      end
    end else if (bus.fault_clr) begin
      r_pc <= RESET_PC;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a combinational instmem model.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(32'h0), .NO_INST(1024), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {12'hC0D, a[21:2]};
  endfunction

  assign bus.inst_in = mem_word(bus.inst_addr);

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        clr;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_fault;
    logic [31:0] e_faddr;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic clr, input logic [31:0] addr, input logic vld,
                             input logic [31:0] pc, input logic [31:0] inst,
                             input logic flt, input logic [31:0] fa);
    vec_t r;
    r.stall = st; r.redirect = rd; r.rpc = rpc; r.clr = clr;
    r.e_addr = addr; r.e_valid = vld; r.e_pc = pc; r.e_inst = inst;
    r.e_fault = flt; r.e_faddr = fa;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic clr);
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc; bus.fault_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},  bus.inst_addr, 32'h0);
    check({tag, "_inst"},  bus.if_inst, NOP);
    check({tag, "_pc"},    bus.if_pc, 32'h0);
    check({tag, "_pc4"},   bus.if_pc4, 32'h0);
    check({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
    check({tag, "_fault"}, {31'd0, bus.fault}, 32'd0);
    check({tag, "_faddr"}, bus.fault_addr, 32'h0);
  endtask

  initial begin
    vecs[0]  = v(0,0,0,0, 32'h4, 1, 32'h0, mem_word(32'h0), 0, 0);
    vecs[1]  = v(0,0,0,0, 32'h8, 1, 32'h4, mem_word(32'h4), 0, 0);
    vecs[2]  = v(1,0,0,0, 32'h8, 1, 32'h4, mem_word(32'h4), 0, 0);
    vecs[3]  = v(1,0,0,0, 32'h8, 1, 32'h4, mem_word(32'h4), 0, 0);
    vecs[4]  = v(1,0,0,0, 32'h8, 1, 32'h4, mem_word(32'h4), 0, 0);
    vecs[5]  = v(0,0,0,0, 32'hC, 1, 32'h8, mem_word(32'h8), 0, 0);
    vecs[6]  = v(0,0,0,0, 32'h10, 1, 32'hC, mem_word(32'hC), 0, 0);
    vecs[7]  = v(1,1,32'h40,0, 32'h40, 0, 32'h10, NOP, 0, 0);
    vecs[8]  = v(0,0,0,0, 32'h44, 1, 32'h40, mem_word(32'h40), 0, 0);
    vecs[9]  = v(0,1,32'h22,0, 32'h22, 0, 32'h44, NOP, 0, 0);
    vecs[10] = v(0,0,0,0, 32'h22, 0, 32'h44, NOP, 1, 32'h22);
    vecs[11] = v(0,1,32'h0,0, 32'h22, 0, 32'h44, NOP, 1, 32'h22);
    vecs[12] = v(1,0,0,0, 32'h22, 0, 32'h44, NOP, 1, 32'h22);
    vecs[13] = v(0,0,0,1, 32'h0, 0, 32'h44, NOP, 0, 32'h22);
    vecs[14] = v(0,0,0,0, 32'h4, 1, 32'h0, mem_word(32'h0), 0, 32'h22);
    vecs[15] = v(0,0,0,1, 32'h8, 1, 32'h4, mem_word(32'h4), 0, 32'h22);
    vecs[16] = v(0,1,32'h1000_0000,0, 32'h1000_0000, 0, 32'h8, NOP, 0, 32'h22);
    vecs[17] = v(0,1,32'h100,0, 32'h100, 0, 32'h1000_0000, NOP, 0, 32'h22);
    vecs[18] = v(0,0,0,0, 32'h104, 1, 32'h100, mem_word(32'h100), 0, 32'h22);

    drive(0, 0, 0, 0);
    #2;
    check_reset("rst_async");
    #10;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].clr);
      step();
      check($sformatf("v%0d_addr", i), bus.inst_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'd0, bus.if_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_pc", i), bus.if_pc, vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i), bus.if_pc4, vecs[i].e_pc + 32'd4);
      check($sformatf("v%0d_inst", i), bus.if_inst, vecs[i].e_inst);
      check($sformatf("v%0d_fault", i), {31'd0, bus.fault}, {31'd0, vecs[i].e_fault});
      check($sformatf("v%0d_faddr", i), bus.fault_addr, vecs[i].e_faddr);
    end

    // PC+4 wrap on the flushed slot of a redirect from the top address
    drive(0, 1, 32'hFFFF_FFFC, 0); step();
    drive(0, 1, 32'hFF8, 0); step();
    check("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.if_pc4, 32'h0);
    check("wrap_fault", {31'd0, bus.fault}, 32'd0);

    // Last valid word, then range fault at word index NO_INST
    drive(0, 0, 0, 0); step();
    check("end_pc0", bus.if_pc, 32'hFF8);
    check("end_valid0", {31'd0, bus.if_valid}, 32'd1);
    step();
    check("end_pc1", bus.if_pc, 32'hFFC);
    check("end_inst1", bus.if_inst, mem_word(32'hFFC));
    check("end_valid1", {31'd0, bus.if_valid}, 32'd1);
    check("end_addr", bus.inst_addr, 32'h1000);
    check("end_nofault", {31'd0, bus.fault}, 32'd0);
    step();
    check("range_fault", {31'd0, bus.fault}, 32'd1);
    check("range_faddr", bus.fault_addr, 32'h1000);
    check("range_valid", {31'd0, bus.if_valid}, 32'd0);
    check("range_inst", bus.if_inst, NOP);
    drive(0, 0, 0, 1); step();
    check("clr_fault", {31'd0, bus.fault}, 32'd0);
    check("clr_addr", bus.inst_addr, 32'h0);

    // Async reset mid-stall
    drive(0, 0, 0, 0); step(); step();
    drive(1, 0, 0, 0); step();
    check("stall_hold_addr", bus.inst_addr, 32'h8);
    #3 rst = 1'b1;
    #1;
    check_reset("rst_stall");
    #2 rst = 1'b0;
    drive(0, 0, 0, 0); step();
    check("post_rst1_pc", bus.if_pc, 32'h0);
    check("post_rst1_valid", {31'd0, bus.if_valid}, 32'd1);
    check("post_rst1_inst", bus.if_inst, mem_word(32'h0));

    // Async reset while in FAULT
    drive(0, 1, 32'h2, 0); step();
    drive(0, 0, 0, 0); step();
    check("mis_fault", {31'd0, bus.fault}, 32'd1);
    check("mis_faddr", bus.fault_addr, 32'h2);
    #3 rst = 1'b1;
    #1;
    check_reset("rst_fault");
    #2 rst = 1'b0;
    step();
    check("post_rst2_pc", bus.if_pc, 32'h0);
    check("post_rst2_valid", {31'd0, bus.if_valid}, 32'd1);
    check("post_rst2_addr", bus.inst_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
